ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
Parametrised successor to the single-cycle main decoder for the pipelined RV32I core. Decodes the Decode-stage opcode into a control bundle and carries that bundle through the E, M and W pipeline registers. Supports stall and flush (bubble insertion) from the hazard unit. Adds decode for jalr, lui and auipc, and per-stage valid bits.

Parameters:
IMMSRC_W, 3, width of ImmSrc: 000 I, 001 S, 010 B, 011 J, 100 U.
ALUOP_W, 2, width of ALUOp handed to the ALU decoder.
RESULTSRC_W, 2, width of ResultSrc: 00 ALU, 01 mem, 10 PC+4, 11 ImmExt.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
OpD  in  7  opcode of the instruction in Decode.
ValidD  in  1  Decode holds a real instruction.
StallE  in  1  hold the E register.
FlushE  in  1  load a bubble into E.
FlushM  in  1  load a bubble into M.
ImmSrcD  out  IMMSRC_W  combinational immediate select for Decode.
RegWriteE, MemWriteE, BranchE, JumpE, JumpRegE, ALUSrcAE, ALUSrcBE  out  1 each  E-stage controls.
ALUOpE  out  ALUOP_W  E-stage ALU op class.
ResultSrcE, ResultSrcM, ResultSrcW  out  RESULTSRC_W each  per-stage result select.
RegWriteM, MemWriteM, RegWriteW  out  1 each  later-stage controls.
ValidE, ValidM, ValidW  out  1 each  stage holds a real instruction.
IllegalW, IllegalSeen  out  1 each  present only with CTRL_ILLEGAL_TRAP_EN.

Behaviour:
- Decode is combinational from OpD.
- Encoding per op: RegWrite, ImmSrc, ALUSrcA, ALUSrcB, MemWrite, ResultSrc, Branch, ALUOp, Jump, JumpReg.
  - lw 0000011: 1,I,0,1,0,01,0,00,0,0.
  - sw 0100011: 0,S,0,1,1,00,0,00,0,0.
  - R 0110011: 1,I,0,0,0,00,0,10,0,0.
  - branch 1100011: 0,B,0,0,0,00,1,01,0,0.
  - I-ALU 0010011: 1,I,0,1,0,00,0,10,0,0.
  - jal 1101111: 1,J,0,0,0,10,0,00,1,0.
  - jalr 1100111: 1,I,0,1,0,10,0,00,0,1.
  - lui 0110111: 1,U,0,0,0,11,0,00,0,0.
  - auipc 0010111: 1,U,1,1,0,00,0,00,0,0.
- Unknown opcode: all-zero bundle, never X.
- Bundle with ValidD=0 is forced to the bubble value. Bubble = all control fields 0, Valid 0.
- Latency: bundle reaches E 1 cycle after Decode, M after 2, W after 3.
- E register, in priority order:
  - FlushE: bubble.
  - else StallE: hold.
  - else load the decoded bundle.
- FlushE and StallE both asserted: flush wins.
- M register:
  - FlushM: bubble.
  - else if StallE: load a bubble. E is held, so the same instruction must not advance twice.
  - else load E.
- W register always loads M.
- Async reset: all E/M/W fields and Valid bits 0 immediately. Reset mid-operation discards in-flight instructions. First valid E appears at the first clk edge after deassertion with ValidD=1.
- Only the fields each stage needs are carried forward.
  - M carries: RegWrite, MemWrite, ResultSrc, Valid.
  - W carries: RegWrite, ResultSrc, Valid.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- When defined:
  - A valid unknown opcode sets an Illegal bit, carried E→M→W with the same stall/flush rules as Valid.
  - IllegalW reports it.
  - IllegalSeen is a sticky flag set when ValidW&IllegalW; cleared only by rst_n.
  - Bubbles carry Illegal=0.
- When undefined: IllegalW and IllegalSeen ports do not exist; unknown opcodes are silent bubbles.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_BRANCH, OP_IALU, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - ImmSrc and ResultSrc encodings;
  - packed struct ctrl_t for the control bundle;
  - constant CTRL_BUBBLE.
- One sub-module is natural: ctrl_decode, the combinational opcode→ctrl_t table, reused by the single-cycle core.
- Pipeline registers stay in ctrl_pipe.

Test Plan:
- Reset: hold rst_n=0 with ValidD=1, OpD=0110011 → all E/M/W outputs and Valid bits 0. Release → RegWriteE=1, ALUOpE=10 one edge later; RegWriteW=1 three edges later.
- Opcode sweep: each of the 9 ops back-to-back → E bundle matches the table. Spot checks:
  - lui: ResultSrcW=11.
  - auipc: ALUSrcAE=1.
  - jalr: JumpRegE=1, ResultSrcE=10.
- Stall: lw in E, StallE=1 for 2 cycles → E holds lw (ResultSrcE=01). M gets 2 bubbles (RegWriteM=0). After release, lw appears in M exactly once.
- Flush: beq in Decode, FlushE=1 with StallE=1 in the same cycle → E becomes bubble (BranchE=0, ValidE=0).
- Unknown op 1111111, ValidD=1:
  - macro off: all-zero bundle in E.
  - macro on: IllegalW=1 three edges later, IllegalSeen stays 1 until rst_n=0.
- Mid-flight reset: sw in M, pulse rst_n low between edges → MemWriteM drops to 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, encodings and control-bundle types for ctrl_decode/ctrl_pipe
package ctrl_pkg;

   localparam int CTRL_IMMSRC_W    = 3;
   localparam int CTRL_ALUOP_W     = 2;
   localparam int CTRL_RESULTSRC_W = 2;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [CTRL_IMMSRC_W-1:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_e;

   typedef enum logic [CTRL_RESULTSRC_W-1:0] {
      RES_ALU  = 2'b00,
      RES_MEM  = 2'b01,
      RES_PC4  = 2'b10,
      RES_IMM  = 2'b11
   } result_src_e;

   localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD  = 2'b00;
   localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SUB  = 2'b01;
   localparam logic [CTRL_ALUOP_W-1:0] ALUOP_FUNC = 2'b10;

   typedef struct packed {
      logic                    reg_write;
      imm_src_e                imm_src;
      logic                    alu_src_a;
      logic                    alu_src_b;
      logic                    mem_write;
      result_src_e             result_src;
      logic                    branch;
      logic [CTRL_ALUOP_W-1:0] alu_op;
      logic                    jump;
      logic                    jump_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   typedef struct packed {
      logic                    reg_write;
      logic                    mem_write;
      logic                    branch;
      logic                    jump;
      logic                    jump_reg;
      logic                    alu_src_a;
      logic                    alu_src_b;
      logic [CTRL_ALUOP_W-1:0] alu_op;
      result_src_e             result_src;
      logic                    valid;
   } ex_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      result_src_e result_src;
      logic        valid;
   } mem_t;

   typedef struct packed {
      logic        reg_write;
      result_src_e result_src;
      logic        valid;
   } wb_t;

   localparam ex_t  EX_BUBBLE  = '0;
   localparam mem_t MEM_BUBBLE = '0;
   localparam wb_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational RV32I opcode to control-bundle table
// Unknown opcodes give CTRL_BUBBLE with o_known=0.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [6:0] i_op,
   output ctrl_t      o_ctrl,
   output logic       o_known
);

   always_comb begin
      o_ctrl  = CTRL_BUBBLE;
      o_known = 1'b1;
      unique case (i_op)
         OP_LOAD: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.imm_src    = IMM_I;
            o_ctrl.alu_src_b  = 1'b1;
            o_ctrl.result_src = RES_MEM;
         end
         OP_STORE: begin
            o_ctrl.imm_src    = IMM_S;
            o_ctrl.alu_src_b  = 1'b1;
            o_ctrl.mem_write  = 1'b1;
         end
         OP_R: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.alu_op     = ALUOP_FUNC;
         end
         OP_BRANCH: begin
            o_ctrl.imm_src    = IMM_B;
            o_ctrl.branch     = 1'b1;
            o_ctrl.alu_op     = ALUOP_SUB;
         end
         OP_IALU: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.alu_src_b  = 1'b1;
            o_ctrl.alu_op     = ALUOP_FUNC;
         end
         OP_JAL: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.imm_src    = IMM_J;
            o_ctrl.result_src = RES_PC4;
            o_ctrl.jump       = 1'b1;
         end
         OP_JALR: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.alu_src_b  = 1'b1;
            o_ctrl.result_src = RES_PC4;
            o_ctrl.jump_reg   = 1'b1;
         end
         // lui bypasses the ALU: W selects ImmExt directly
         OP_LUI: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.imm_src    = IMM_U;
            o_ctrl.result_src = RES_IMM;
         end
         OP_AUIPC: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.imm_src    = IMM_U;
            o_ctrl.alu_src_a  = 1'b1;
            o_ctrl.alu_src_b  = 1'b1;
         end
         default: o_known = 1'b0;
      endcase
   end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - decode plus E/M/W control pipeline registers with stall/flush bubbles
// Optional CTRL_ILLEGAL_TRAP_EN adds IllegalW/IllegalSeen for valid unknown opcodes.
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int IMMSRC_W    = CTRL_IMMSRC_W,
   parameter int ALUOP_W     = CTRL_ALUOP_W,
   parameter int RESULTSRC_W = CTRL_RESULTSRC_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [6:0]             OpD,
   input  logic                   ValidD,
   input  logic                   StallE,
   input  logic                   FlushE,
   input  logic                   FlushM,
   output logic [IMMSRC_W-1:0]    ImmSrcD,
   output logic                   RegWriteE,
   output logic                   MemWriteE,
   output logic                   BranchE,
   output logic                   JumpE,
   output logic                   JumpRegE,
   output logic                   ALUSrcAE,
   output logic                   ALUSrcBE,
   output logic [ALUOP_W-1:0]     ALUOpE,
   output logic [RESULTSRC_W-1:0] ResultSrcE,
   output logic [RESULTSRC_W-1:0] ResultSrcM,
   output logic [RESULTSRC_W-1:0] ResultSrcW,
   output logic                   RegWriteM,
   output logic                   MemWriteM,
   output logic                   RegWriteW,
   output logic                   ValidE,
   output logic                   ValidM,
`ifdef CTRL_ILLEGAL_TRAP_EN
   output logic                   ValidW,
   output logic                   IllegalW,
   output logic                   IllegalSeen
`else
   output logic                   ValidW
`endif
);

   ctrl_t w_dec;
   logic  w_known;
   logic  w_take;
   ex_t   w_ex_d;
   ex_t   r_e;
   mem_t  r_m;
   wb_t   r_w;

   ctrl_decode u_decode (
      .i_op    (OpD),
      .o_ctrl  (w_dec),
      .o_known (w_known)
   );

   // With the trap enabled an unknown opcode stays a valid (illegal) instruction
   always_comb begin
      w_ex_d = EX_BUBBLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
      w_take = ValidD;
`else
      w_take = ValidD & w_known;
`endif
      if (w_take) begin
         w_ex_d.reg_write  = w_dec.reg_write;
         w_ex_d.mem_write  = w_dec.mem_write;
         w_ex_d.branch     = w_dec.branch;
         w_ex_d.jump       = w_dec.jump;
         w_ex_d.jump_reg   = w_dec.jump_reg;
         w_ex_d.alu_src_a  = w_dec.alu_src_a;
         w_ex_d.alu_src_b  = w_dec.alu_src_b;
         w_ex_d.alu_op     = w_dec.alu_op;
         w_ex_d.result_src = w_dec.result_src;
         w_ex_d.valid      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_e <= EX_BUBBLE;
      else if (FlushE)  r_e <= EX_BUBBLE;
      else if (!StallE) r_e <= w_ex_d;
   end

   // A held E must not also advance into M, so a stall feeds M a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m <= MEM_BUBBLE;
      end else if (FlushM || StallE) begin
         r_m <= MEM_BUBBLE;
      end else begin
         r_m.reg_write  <= r_e.reg_write;
         r_m.mem_write  <= r_e.mem_write;
         r_m.result_src <= r_e.result_src;
         r_m.valid      <= r_e.valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w <= WB_BUBBLE;
      end else begin
         r_w.reg_write  <= r_m.reg_write;
         r_w.result_src <= r_m.result_src;
         r_w.valid      <= r_m.valid;
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic r_illegal_e;
   logic r_illegal_m;
   logic r_illegal_w;
   logic r_seen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal_e <= 1'b0;
         r_illegal_m <= 1'b0;
         r_illegal_w <= 1'b0;
         r_seen      <= 1'b0;
      end else begin
         if (FlushE)       r_illegal_e <= 1'b0;
         else if (!StallE) r_illegal_e <= ValidD & ~w_known;
         r_illegal_m <= (FlushM || StallE) ? 1'b0 : r_illegal_e;
         r_illegal_w <= r_illegal_m;
         if (r_w.valid && r_illegal_w) r_seen <= 1'b1;
      end
   end

   assign IllegalW    = r_illegal_w;
   assign IllegalSeen = r_seen;
`endif

   assign ImmSrcD    = IMMSRC_W'(w_dec.imm_src);
   assign RegWriteE  = r_e.reg_write;
   assign MemWriteE  = r_e.mem_write;
   assign BranchE    = r_e.branch;
   assign JumpE      = r_e.jump;
   assign JumpRegE   = r_e.jump_reg;
   assign ALUSrcAE   = r_e.alu_src_a;
   assign ALUSrcBE   = r_e.alu_src_b;
   assign ALUOpE     = ALUOP_W'(r_e.alu_op);
   assign ResultSrcE = RESULTSRC_W'(r_e.result_src);
   assign ValidE     = r_e.valid;
   assign RegWriteM  = r_m.reg_write;
   assign MemWriteM  = r_m.mem_write;
   assign ResultSrcM = RESULTSRC_W'(r_m.result_src);
   assign ValidM     = r_m.valid;
   assign RegWriteW  = r_w.reg_write;
   assign ResultSrcW = RESULTSRC_W'(r_w.result_src);
   assign ValidW     = r_w.valid;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed and randomized bench for ctrl_pipe against a slot-level reference model
module tb_ctrl_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] OpD;
   logic       ValidD, StallE, FlushE, FlushM;
   logic [2:0] ImmSrcD;
   logic       RegWriteE, MemWriteE, BranchE, JumpE, JumpRegE, ALUSrcAE, ALUSrcBE;
   logic [1:0] ALUOpE, ResultSrcE, ResultSrcM, ResultSrcW;
   logic       RegWriteM, MemWriteM, RegWriteW, ValidE, ValidM, ValidW;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic       IllegalW, IllegalSeen;
`endif

   always #5 clk = ~clk;

   ctrl_pipe dut (
      .clk(clk), .rst_n(rst_n), .OpD(OpD), .ValidD(ValidD),
      .StallE(StallE), .FlushE(FlushE), .FlushM(FlushM),
      .ImmSrcD(ImmSrcD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .BranchE(BranchE), .JumpE(JumpE), .JumpRegE(JumpRegE),
      .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ALUOpE(ALUOpE),
      .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW),
      .ValidE(ValidE), .ValidM(ValidM),
`ifdef CTRL_ILLEGAL_TRAP_EN
      .ValidW(ValidW), .IllegalW(IllegalW), .IllegalSeen(IllegalSeen)
`else
      .ValidW(ValidW)
`endif
   );

   // Model: each stage holds an instruction slot; fields come from the opcode table
   typedef struct {bit v; bit ill; bit [6:0] op;} slot_t;
   slot_t me, mm, mw, bub;
   bit    mseen;
   int    checks = 0;
   int    failures = 0;

   localparam bit [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011,
                        BR = 7'b1100011, IA = 7'b0010011, JAL = 7'b1101111,
                        JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
   bit [6:0] ops [9] = '{LW, SW, RR, BR, IA, JAL, JALR, LUI, AUIPC};

   // {RegWrite, ImmSrc[3], ALUSrcA, ALUSrcB, MemWrite, ResultSrc[2], Branch, ALUOp[2], Jump, JumpReg}
   function automatic logic [13:0] tbl(input logic [6:0] op);
      case (op)
         LW:      return {1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
         SW:      return {1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
         RR:      return {1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
         BR:      return {1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0};
         IA:      return {1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
         JAL:     return {1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b0};
         JALR:    return {1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1};
         LUI:     return {1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
         AUIPC:   return {1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
         default: return 14'd0;
      endcase
   endfunction

   function automatic bit known(input logic [6:0] op);
      return op inside {LW, SW, RR, BR, IA, JAL, JALR, LUI, AUIPC};
   endfunction

   function automatic slot_t dec(input bit vd, input logic [6:0] op);
      slot_t s;
      s.op = op;
`ifdef CTRL_ILLEGAL_TRAP_EN
      s.v   = vd;
      s.ill = vd && !known(op);
`else
      s.v   = vd && known(op);
      s.ill = 1'b0;
`endif
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      me = bub; mm = bub; mw = bub; mseen = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         if (mw.v && mw.ill) mseen = 1'b1;
         mw = mm;
         mm = (FlushM || StallE) ? bub : me;
         if (FlushE)       me = bub;
         else if (!StallE) me = dec(ValidD, OpD);
      end
      #1;
   endtask

   task automatic check_all(input string tag);
      logic [13:0] fd, fe, fm, fw;
      fd = tbl(OpD);
      fe = me.v ? tbl(me.op) : 14'd0;
      fm = mm.v ? tbl(mm.op) : 14'd0;
      fw = mw.v ? tbl(mw.op) : 14'd0;
      chk({tag, ".ImmSrcD"},    ImmSrcD,    fd[12:10]);
      chk({tag, ".RegWriteE"},  RegWriteE,  fe[13]);
      chk({tag, ".ALUSrcAE"},   ALUSrcAE,   fe[9]);
      chk({tag, ".ALUSrcBE"},   ALUSrcBE,   fe[8]);
      chk({tag, ".MemWriteE"},  MemWriteE,  fe[7]);
      chk({tag, ".ResultSrcE"}, ResultSrcE, fe[6:5]);
      chk({tag, ".BranchE"},    BranchE,    fe[4]);
      chk({tag, ".ALUOpE"},     ALUOpE,     fe[3:2]);
      chk({tag, ".JumpE"},      JumpE,      fe[1]);
      chk({tag, ".JumpRegE"},   JumpRegE,   fe[0]);
      chk({tag, ".ValidE"},     ValidE,     me.v);
      chk({tag, ".RegWriteM"},  RegWriteM,  fm[13]);
      chk({tag, ".MemWriteM"},  MemWriteM,  fm[7]);
      chk({tag, ".ResultSrcM"}, ResultSrcM, fm[6:5]);
      chk({tag, ".ValidM"},     ValidM,     mm.v);
      chk({tag, ".RegWriteW"},  RegWriteW,  fw[13]);
      chk({tag, ".ResultSrcW"}, ResultSrcW, fw[6:5]);
      chk({tag, ".ValidW"},     ValidW,     mw.v);
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk({tag, ".IllegalW"},    IllegalW,    mw.ill);
      chk({tag, ".IllegalSeen"}, IllegalSeen, mseen);
`endif
   endtask

   initial begin
      bit [6:0] sweep [11];
      bub = '{v: 1'b0, ill: 1'b0, op: 7'd0};
      model_reset();
      rst_n = 1'b0; ValidD = 1'b1; OpD = RR;
      StallE = 1'b0; FlushE = 1'b0; FlushM = 1'b0;

      // Reset held with a valid R-type in Decode
      tick(); tick();
      check_all("reset");
      chk("reset.ValidE", ValidE, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("rel.RegWriteE", RegWriteE, 1'b1);
      chk("rel.ALUOpE", ALUOpE, 2'b10);
      tick(); tick();
      chk("rel.RegWriteW", RegWriteW, 1'b1);
      check_all("rel");

      // Opcode sweep, padded so the tail reaches W
      foreach (ops[i]) sweep[i] = ops[i];
      sweep[9] = RR; sweep[10] = RR;
      for (int i = 0; i < 11; i++) begin
         OpD = sweep[i];
         tick();
         check_all("sweep");
         if (sweep[i] == AUIPC) chk("sweep.auipc.ALUSrcAE", ALUSrcAE, 1'b1);
         if (sweep[i] == JALR) begin
            chk("sweep.jalr.JumpRegE", JumpRegE, 1'b1);
            chk("sweep.jalr.ResultSrcE", ResultSrcE, 2'b10);
         end
         if (i >= 2 && sweep[i-2] == LUI) chk("sweep.lui.ResultSrcW", ResultSrcW, 2'b11);
      end

      // Stall: lw held in E for two cycles, M gets bubbles, lw enters M once
      OpD = LW; tick();
      StallE = 1'b1; OpD = SW;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("stall.ResultSrcE", ResultSrcE, 2'b01);
         chk("stall.RegWriteM", RegWriteM, 1'b0);
         check_all("stall");
      end
      StallE = 1'b0; OpD = RR;
      tick();
      chk("stall.lwM.ResultSrcM", ResultSrcM, 2'b01);
      chk("stall.lwM.RegWriteM", RegWriteM, 1'b1);
      tick();
      chk("stall.once.ResultSrcM", ResultSrcM, 2'b00);
      check_all("stall.after");

      // Flush wins over stall
      OpD = BR; FlushE = 1'b1; StallE = 1'b1;
      tick();
      chk("flush.BranchE", BranchE, 1'b0);
      chk("flush.ValidE", ValidE, 1'b0);
      check_all("flush");
      FlushE = 1'b0; StallE = 1'b0;

      // Unknown opcode with ValidD=1
      OpD = 7'b1111111;
      tick();
      check_all("unk");
      OpD = RR;
      tick(); tick();
      check_all("unk.w");
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk("unk.IllegalW", IllegalW, 1'b1);
      tick();
      chk("unk.IllegalSeen", IllegalSeen, 1'b1);
`else
      chk("unk.ValidW", ValidW, 1'b0);
`endif

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         int r;
         r = $urandom_range(0, 9);
         OpD    = (r == 9) ? 7'($urandom) : ops[r];
         ValidD = ($urandom_range(0, 7) != 0);
         StallE = ($urandom_range(0, 3) == 0);
         FlushE = ($urandom_range(0, 7) == 0);
         FlushM = ($urandom_range(0, 7) == 0);
         tick();
         check_all("rand");
      end

      // Mid-flight async reset with sw in M
      ValidD = 1'b1; StallE = 1'b0; FlushE = 1'b0; FlushM = 1'b0;
      OpD = SW; tick();
      OpD = RR; tick();
      chk("midrst.pre.MemWriteM", MemWriteM, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.MemWriteM", MemWriteM, 1'b0);
      model_reset();
      check_all("midrst");
      #1 rst_n = 1'b1;
      tick();
      check_all("midrst.rel");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
